// File: rtl/fixed_to_int_packer.sv
// fixed_to_int_packer
//
// Converts signed fixed-point words (INT_BITS.FRAC_BITS, two's complement)
// into unsigned OUTPUT_BITS integers and packs NUM_INTEGERS of them into
// one wide output block.
//
// Conversion: round half toward +infinity (add 2^(FRAC_BITS-1), arithmetic
// shift right by FRAC_BITS), then saturate into [0, 2^OUTPUT_BITS-1].
//
// Handshake (both sides): a transfer happens on a rising edge where valid
// and ready are both 1. in_ready is 1 only in FILL and out_valid is 1 only
// in HOLD, so the block either accepts words or offers a finished block,
// never both. Once out_valid is up, integers and out_valid stay stable until
// the edge that sees out_ready=1.
//
// Ports:
//   clk        - clock, all logic on the rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - fixed_in holds a valid word
//   in_ready   - block accepts a word this cycle (FILL)
//   fixed_in   - signed fixed-point input word
//   out_valid  - integers holds a complete block (HOLD)
//   out_ready  - consumer takes the block this cycle
//   integers   - packed block, element i at [i*OUTPUT_BITS +: OUTPUT_BITS]
//   sat_count  - (only with FIXED_TO_INT_SAT_COUNT_EN) number of clamped
//                words in the current block
//
// Optional feature macro: FIXED_TO_INT_SAT_COUNT_EN

module fixed_to_int_packer #(
    parameter int INT_BITS     = 16,
    parameter int FRAC_BITS    = 16,
    parameter int OUTPUT_BITS  = 8,
    parameter int NUM_INTEGERS = 64
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [INT_BITS+FRAC_BITS-1:0]         fixed_in,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [NUM_INTEGERS*OUTPUT_BITS-1:0]   integers
`ifdef FIXED_TO_INT_SAT_COUNT_EN
    ,
    output logic [$clog2(NUM_INTEGERS+1)-1:0]     sat_count
`endif
);

    localparam int W  = INT_BITS + FRAC_BITS;
    // Working width: wide enough that the rounding add cannot overflow and
    // that the saturation limit is representable as a positive number.
    localparam int XW = (W + 1 > OUTPUT_BITS + 1) ? W + 1 : OUTPUT_BITS + 1;
    localparam int IW = (NUM_INTEGERS > 1) ? $clog2(NUM_INTEGERS) : 1;

    localparam logic [XW-1:0] HALF     = XW'(1) << (FRAC_BITS - 1);
    localparam logic [XW-1:0] MAX_U    = (XW'(1) << OUTPUT_BITS) - XW'(1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_INTEGERS - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [IW-1:0]           idx_q;
    logic                    accept;
    logic signed [XW-1:0]    word_ext;
    logic signed [XW-1:0]    rsum;
    logic signed [XW-1:0]    rounded;
    logic                    clamp;
    logic [OUTPUT_BITS-1:0]  conv;

    // ---------------- conversion datapath ----------------
    always_comb begin
        word_ext = XW'($signed(fixed_in));
        rsum     = word_ext + HALF;
        rounded  = rsum >>> FRAC_BITS;
        clamp    = 1'b0;
        conv     = rounded[OUTPUT_BITS-1:0];
        if (rounded[XW-1]) begin
            clamp = 1'b1;
            conv  = '0;
        end else if (rounded > $signed(MAX_U)) begin
            clamp = 1'b1;
            conv  = '1;
        end
    end

    // ---------------- control FSM ----------------
    assign accept = in_valid && (state_q == FILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                if (accept && (idx_q == LAST_IDX)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // ---------------- slot index and storage ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (accept) begin
            idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        end
    end

    // Slots keep their old contents until rewritten; out_valid alone says
    // whether the whole vector belongs to one block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integers <= '0;
        end else if (accept) begin
            integers[idx_q*OUTPUT_BITS +: OUTPUT_BITS] <= conv;
        end
    end

`ifdef FIXED_TO_INT_SAT_COUNT_EN
    localparam int SCW = $clog2(NUM_INTEGERS + 1);

    // Restarts on the first accept of a block (slot 0), so the value seen
    // during HOLD covers exactly the block being offered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (accept) begin
            sat_count <= ((idx_q == '0) ? '0 : sat_count) + SCW'(clamp);
        end
    end
`endif

endmodule

// File: tb/tb_fixed_to_int_packer.sv
// Bench for fixed_to_int_packer with default parameters.
module tb_fixed_to_int_packer;

    localparam int INT_BITS  = 16;
    localparam int FRAC_BITS = 16;
    localparam int OB        = 8;
    localparam int N         = 64;
    localparam int W         = INT_BITS + FRAC_BITS;
    localparam int BW        = N * OB;

    // ---------------- clock / reset / DUT ----------------
    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  fixed_in  = '0;
    logic          in_ready;
    logic          out_valid;
    logic [BW-1:0] integers;
`ifdef FIXED_TO_INT_SAT_COUNT_EN
    logic [$clog2(N+1)-1:0] sat_count;
`endif

    always #5 clk = ~clk;

    fixed_to_int_packer #(
        .INT_BITS    (INT_BITS),
        .FRAC_BITS   (FRAC_BITS),
        .OUTPUT_BITS (OB),
        .NUM_INTEGERS(N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .fixed_in (fixed_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef FIXED_TO_INT_SAT_COUNT_EN
        .sat_count(sat_count),
`endif
        .integers (integers)
    );

    // ---------------- scoreboard / model ----------------
    int checks = 0;
    int errors = 0;
    logic [OB-1:0] model_slot [N];
    int            model_cnt = 0;
    int            model_sat = 0;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] hold_blk;

    // Real-valued reference: value = word / 2^FRAC_BITS, round half up, clamp.
    function automatic logic [OB-1:0] ref_conv(input logic [W-1:0] w, output bit clamped);
        longint v;
        real    x;
        longint r;
        longint maxv;
        v    = longint'($signed(w));
        x    = real'(v) / (2.0 ** FRAC_BITS);
        r    = longint'($floor(x + 0.5));
        maxv = (longint'(1) << OB) - 1;
        clamped = 1'b0;
        if (r < 0) begin
            clamped = 1'b1;
            return '0;
        end
        if (r > maxv) begin
            clamped = 1'b1;
            return '1;
        end
        return OB'(r);
    endfunction

    function automatic logic [OB-1:0] dut_slot(input int i);
        return integers[i*OB +: OB];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) model_slot[i] = '0;
        model_cnt = 0;
        model_sat = 0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [W-1:0] w);
        bit            c;
        logic [OB-1:0] v;
        logic [BW-1:0] blk;
        v = ref_conv(w, c);
        if (model_cnt == 0) model_sat = 0;
        model_slot[model_cnt] = v;
        if (c) model_sat++;
        model_cnt++;
        if (model_cnt == N) begin
            for (int i = 0; i < N; i++) blk[i*OB +: OB] = model_slot[i];
            exp_q.push_back(blk);
            model_cnt = 0;
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        case ($urandom_range(0, 3))
            0: w = {8'h00, 8'($urandom_range(0, 255)), 16'($urandom)};
            1: w = W'($urandom);
            2: w = -W'($urandom_range(0, 32'h3_FFFF));
            default: w = {16'($urandom_range(16'h00FE, 16'h0100)), 16'($urandom)};
        endcase
        return w;
    endfunction

    // ---------------- drivers ----------------
    // Presents w from a falling edge and waits (bounded) for the rising edge
    // that accepts it; returns 1 time unit after that edge.
    task automatic send_word(input logic [W-1:0] w);
        int waited;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        fixed_in = w;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_word_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            model_accept(w);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            fixed_in = W'($urandom);
        end
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %0b required 0", out_valid);
        end
        checks++;
        if (integers !== '0) begin
            errors++;
            $display("FAIL reset_integers: got %0h required 0", integers);
        end
`ifdef FIXED_TO_INT_SAT_COUNT_EN
        checks++;
        if (sat_count !== '0) begin
            errors++;
            $display("FAIL reset_sat_count: got %0d required 0", sat_count);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        end
    endtask

    task automatic test_rounding();
        logic [W-1:0] words [4];
        logic [BW-1:0] blk;
        words[0] = 32'h0040_8000;
        words[1] = 32'h0040_7FFF;
        words[2] = 32'hFFFF_8000;
        words[3] = 32'h0000_0000;
        for (int i = 0; i < 4; i++) send_word(words[i]);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut_slot(i) !== model_slot[i]) begin
                errors++;
                $display("FAIL rounding_slot%0d: got %0d required %0d", i, dut_slot(i), model_slot[i]);
            end
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rounding_partial_out_valid: got %0b required 0", out_valid);
        end
        for (int k = 4; k < N; k++) send_word(rand_word());
        checks++;
        if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL rounding_block_ready: out_valid=%0b queued=%0d, required 1 and 1", out_valid, exp_q.size());
        end else begin
            blk = exp_q.pop_front();
            checks++;
            if (integers !== blk) begin
                errors++;
                $display("FAIL rounding_block: got %0h required %0h", integers, blk);
            end
        end
        drain();
    endtask

    task automatic test_saturation();
        logic [W-1:0] words [4];
        logic [BW-1:0] blk;
        words[0] = 32'h0100_0000;
        words[1] = 32'h7FFF_FFFF;
        words[2] = 32'h8000_0000;
        words[3] = 32'h00FF_7FFF;
        for (int i = 0; i < 4; i++) send_word(words[i]);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut_slot(i) !== model_slot[i]) begin
                errors++;
                $display("FAIL saturation_slot%0d: got %0d required %0d", i, dut_slot(i), model_slot[i]);
            end
        end
`ifdef FIXED_TO_INT_SAT_COUNT_EN
        checks++;
        if (int'(sat_count) !== model_sat) begin
            errors++;
            $display("FAIL saturation_count4: got %0d required %0d", sat_count, model_sat);
        end
`endif
        for (int k = 4; k < N; k++) send_word(rand_word());
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL saturation_block_queue: got 0 blocks required 1");
        end else begin
            blk = exp_q.pop_front();
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (out_valid !== 1'b1 || integers !== blk) begin
                    errors++;
                    $display("FAIL saturation_hold_c%0d: out_valid=%0b got %0h required %0h", c, out_valid, integers, blk);
                end
`ifdef FIXED_TO_INT_SAT_COUNT_EN
                checks++;
                if (int'(sat_count) !== model_sat) begin
                    errors++;
                    $display("FAIL saturation_hold_count_c%0d: got %0d required %0d", c, sat_count, model_sat);
                end
`endif
                @(posedge clk);
                #1;
            end
        end
        drain();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL saturation_drain: in_ready=%0b out_valid=%0b required 1 and 0", in_ready, out_valid);
        end
    endtask

    // Leaves the DUT in HOLD with hold_blk set to the expected block.
    task automatic test_full_block();
        for (int k = 0; k < N; k++) begin
            send_word(W'(k) << FRAC_BITS);
            if (k == N - 2) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL full_early_out_valid: got %0b required 0", out_valid);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_hold_flags: out_valid=%0b in_ready=%0b required 1 and 0", out_valid, in_ready);
        end
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL full_block_queue: got 0 blocks required 1");
            hold_blk = '0;
        end else begin
            hold_blk = exp_q.pop_front();
            for (int k = 0; k < N; k++) begin
                checks++;
                if (dut_slot(k) !== hold_blk[k*OB +: OB]) begin
                    errors++;
                    $display("FAIL full_slot%0d: got %0d required %0d", k, dut_slot(k), hold_blk[k*OB +: OB]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0]  w;
        logic [BW-1:0] blk;
        @(negedge clk);
        in_valid  = 1'b1;
        fixed_in  = rand_word();
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || integers !== hold_blk) begin
                errors++;
                $display("FAIL backpressure_c%0d: out_valid=%0b in_ready=%0b integers=%0h required 1, 0, %0h",
                         c, out_valid, in_ready, integers, hold_blk);
            end
            fixed_in = rand_word();
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: in_ready=%0b out_valid=%0b required 1 and 0", in_ready, out_valid);
        end
        w = 32'h0012_C000;
        send_word(w);
        checks++;
        if (dut_slot(0) !== model_slot[0]) begin
            errors++;
            $display("FAIL backpressure_slot0: got %0d required %0d", dut_slot(0), model_slot[0]);
        end
        checks++;
        if (dut_slot(1) !== hold_blk[OB +: OB]) begin
            errors++;
            $display("FAIL backpressure_retained_slot1: got %0d required %0d", dut_slot(1), hold_blk[OB +: OB]);
        end
        for (int k = 1; k < N; k++) send_word(rand_word());
        checks++;
        if (exp_q.size() == 0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_block_ready: out_valid=%0b queued=%0d required 1 and 1", out_valid, exp_q.size());
        end else begin
            blk = exp_q.pop_front();
            checks++;
            if (integers !== blk) begin
                errors++;
                $display("FAIL backpressure_block: got %0h required %0h", integers, blk);
            end
        end
        drain();
    endtask

    task automatic test_gapped();
        for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            send_word(W'(k) << FRAC_BITS);
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL gapped_out_valid: got %0b required 1", out_valid);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (dut_slot(k) !== hold_blk[k*OB +: OB]) begin
                errors++;
                $display("FAIL gapped_slot%0d: got %0d required %0d", k, dut_slot(k), hold_blk[k*OB +: OB]);
            end
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        drain();
    endtask

    task automatic test_reset_mid_block();
        logic [BW-1:0] blk;
        for (int k = 0; k < 20; k++) send_word(rand_word());
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || integers !== '0) begin
            errors++;
            $display("FAIL midreset_clear: out_valid=%0b integers=%0h required 0 and 0", out_valid, integers);
        end
`ifdef FIXED_TO_INT_SAT_COUNT_EN
        checks++;
        if (sat_count !== '0) begin
            errors++;
            $display("FAIL midreset_sat_count: got %0d required 0", sat_count);
        end
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < N; k++) begin
            send_word(rand_word());
            if (k == 0) begin
                checks++;
                if (dut_slot(0) !== model_slot[0] || dut_slot(1) !== 8'd0) begin
                    errors++;
                    $display("FAIL midreset_first_slot: slot0=%0d slot1=%0d required %0d and 0",
                             dut_slot(0), dut_slot(1), model_slot[0]);
                end
            end
        end
        checks++;
        if (exp_q.size() == 0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_block_ready: out_valid=%0b queued=%0d required 1 and 1", out_valid, exp_q.size());
        end else begin
            blk = exp_q.pop_front();
            checks++;
            if (integers !== blk) begin
                errors++;
                $display("FAIL midreset_block: got %0h required %0h", integers, blk);
            end
        end
        drain();
    endtask

    task automatic test_random_blocks();
        logic [BW-1:0] blk;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                send_word(rand_word());
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL random_b%0d_queue: got 0 blocks required 1", b);
            end else begin
                blk = exp_q.pop_front();
                for (int c = 0; c < int'($urandom_range(1, 5)); c++) begin
                    @(negedge clk);
                    in_valid = 1'($urandom_range(0, 1));
                    fixed_in = W'($urandom);
                    checks++;
                    if (out_valid !== 1'b1 || integers !== blk) begin
                        errors++;
                        $display("FAIL random_b%0d_hold: out_valid=%0b got %0h required %0h", b, out_valid, integers, blk);
                    end
`ifdef FIXED_TO_INT_SAT_COUNT_EN
                    checks++;
                    if (int'(sat_count) !== model_sat) begin
                        errors++;
                        $display("FAIL random_b%0d_sat_count: got %0d required %0d", b, sat_count, model_sat);
                    end
`endif
                end
            end
            drain();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_full_block();
        test_backpressure();
        test_gapped();
        test_reset_mid_block();
        test_random_blocks();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

    // Hard time bound in case a test hangs outside a bounded wait.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time exceeded, required completion");
        errors++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
